// File: rtl/mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module : mips_instr_encoder
// Brief  : Symbolic request -> 32-bit MIPS word encoder with pseudo-op expansion.
// Rev    : 1.0  initial release
// ============================================================================
module mips_instr_encoder #(
  parameter int COUNT_WIDTH   = 16,
  parameter bit ENABLE_PSEUDO = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_op,
  input  logic [4:0]             in_rs,
  input  logic [4:0]             in_rt,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_shamt,
  input  logic [31:0]            in_imm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_instr,
  output logic                   out_last,
  output logic                   err,
  output logic [COUNT_WIDTH-1:0] word_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_HOLD  = 2'd1,
    S_HOLD2 = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            instr_q, instr_d;
  logic [31:0]            pend_q, pend_d;
  logic                   last_q, last_d;
  logic                   err_q, err_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic [31:0] enc_w0, enc_w1;
  logic        enc_two, enc_illegal;
  logic        accept, fire, load;

  wire [15:0] imm_hi = in_imm[31:16];
  wire [15:0] imm_lo = in_imm[15:0];

  always_comb begin
    enc_w0      = 32'h0000_0000;
    enc_w1      = 32'h0000_0000;
    enc_two     = 1'b0;
    enc_illegal = 1'b0;
    case (in_op)
      4'd0:  enc_w0 = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h21};
      4'd1:  enc_w0 = {6'h00, in_rs, in_rt, in_rd, 5'd0, 6'h23};
      4'd2:  enc_w0 = {6'h00, 5'd0, in_rt, in_rd, in_shamt, 6'h00};
      4'd3:  enc_w0 = {6'h00, in_rs, 15'd0, 6'h08};
      4'd4:  enc_w0 = {6'h00, 20'd0, 6'h0C};
      4'd5:  enc_w0 = {6'h0D, in_rs, in_rt, imm_lo};
      4'd6:  enc_w0 = {6'h23, in_rs, in_rt, imm_lo};
      4'd7:  enc_w0 = {6'h2B, in_rs, in_rt, imm_lo};
      4'd8:  enc_w0 = {6'h04, in_rs, in_rt, imm_lo};
      4'd9:  enc_w0 = {6'h0F, 5'd0, in_rt, imm_lo};
      4'd10: enc_w0 = {6'h03, in_imm[25:0]};
      4'd11: enc_w0 = {6'h02, in_imm[25:0]};
      4'd12: begin
        if (!ENABLE_PSEUDO) begin
          enc_illegal = 1'b1;
        end else if (imm_hi == 16'h0000) begin
          enc_w0 = {6'h0D, 5'd0, in_rt, imm_lo};
        end else if (imm_lo == 16'h0000) begin
          enc_w0 = {6'h0F, 5'd0, in_rt, imm_hi};
        end else begin
          // LUI first, ORI into the same register is parked until the LUI drains
          enc_w0  = {6'h0F, 5'd0, in_rt, imm_hi};
          enc_w1  = {6'h0D, in_rt, in_rt, imm_lo};
          enc_two = 1'b1;
        end
      end
      4'd13: begin
        enc_illegal = !ENABLE_PSEUDO;
        enc_w0      = {6'h00, in_rs, 5'd0, in_rd, 5'd0, 6'h21};
      end
      4'd14:   enc_illegal = !ENABLE_PSEUDO;
      default: enc_illegal = 1'b1;
    endcase
  end

  assign out_valid = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign load      = accept && !enc_illegal;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pend_d  = pend_q;
    last_d  = last_q;
    err_d   = accept && enc_illegal;
    count_d = fire ? count_q + {{(COUNT_WIDTH-1){1'b0}}, 1'b1} : count_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if (load) begin
          state_d = enc_two ? S_HOLD2 : S_HOLD;
          instr_d = enc_w0;
          pend_d  = enc_w1;
          last_d  = !enc_two;
        end else if ((state_q == S_HOLD) && fire) begin
          state_d = S_IDLE;
        end
      end
      S_HOLD2: begin
        if (fire) begin
          state_d = S_HOLD;
          instr_d = pend_q;
          last_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      instr_q <= 32'h0000_0000;
      pend_q  <= 32'h0000_0000;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pend_q  <= pend_d;
      last_q  <= last_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign out_instr  = instr_q;
  assign out_last   = last_q;
  assign err        = err_q;
  assign word_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_mips_instr_encoder
// Brief  : Scoreboard bench for mips_instr_encoder (directed vectors).
// Rev    : 1.0  initial release
// ============================================================================
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_last, err;
  logic [3:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [31:0] in_imm, out_instr;
  logic [15:0] word_count;

  logic        b_valid, b_in_ready, b_out_valid, b_out_last, b_err;
  logic [3:0]  b_op;
  logic [31:0] b_out_instr;
  logic [1:0]  b_count;

  always #5 clk = ~clk;

  mips_instr_encoder #(.COUNT_WIDTH(16), .ENABLE_PSEUDO(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_last(out_last), .err(err), .word_count(word_count)
  );

  mips_instr_encoder #(.COUNT_WIDTH(2), .ENABLE_PSEUDO(1'b0)) dut_np (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_in_ready), .in_op(b_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_instr(b_out_instr),
    .out_last(b_out_last), .err(b_err), .word_count(b_count)
  );

  typedef struct packed {
    logic [31:0] w;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   bad    = 0;
  int   pushed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every accepted output word is checked against the oldest expectation
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h expected none", out_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("word", out_instr, e.w);
        chk("last", {31'd0, out_last}, {31'd0, e.l});
      end
    end
  end

  task automatic to_drive();
    @(posedge clk);
    #2;
  endtask

  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [4:0] sh, input logic [31:0] imm,
                      input int n, input logic [31:0] w0, input logic [31:0] w1);
    int k;
    in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_shamt = sh; in_imm = imm;
    in_valid = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 for op %0d", op);
    end else begin
      if (n == 1) sb.push_back('{w: w0, l: 1'b1});
      if (n == 2) begin
        sb.push_back('{w: w0, l: 1'b0});
        sb.push_back('{w: w1, l: 1'b1});
      end
      pushed += n;
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    @(negedge clk);
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; b_valid = 1'b0; b_op = 4'd0;
    in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_shamt = 5'd0; in_imm = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_last", {31'd0, out_last}, 0);
    chk("rst_err", {31'd0, err}, 0);
    chk("rst_count", {16'd0, word_count}, 0);
    to_drive();
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, in_ready}, 1);
    to_drive();

    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 1, 32'h0022_1821, 0);
    @(negedge clk);
    chk("latency_valid", {31'd0, out_valid}, 1);
    to_drive();
    send(4'd1, 5'd4, 5'd5, 5'd6, 5'd0, 32'd0, 1, 32'h0085_3023, 0);
    send(4'd2, 5'd7, 5'd9, 5'd10, 5'd4, 32'd0, 1, 32'h0009_5100, 0);
    send(4'd3, 5'd31, 5'd2, 5'd3, 5'd1, 32'd0, 1, 32'h03E0_0008, 0);
    send(4'd4, 5'd1, 5'd2, 5'd3, 5'd4, 32'hFFFF_FFFF, 1, 32'h0000_000C, 0);
    send(4'd5, 5'd1, 5'd2, 5'd5, 5'd0, 32'hFFFF_1234, 1, 32'h3422_1234, 0);
    send(4'd6, 5'd29, 5'd8, 5'd0, 5'd0, 32'h0000_0004, 1, 32'h8FA8_0004, 0);
    send(4'd7, 5'd29, 5'd31, 5'd0, 5'd0, 32'h0000_FFFC, 1, 32'hAFBF_FFFC, 0);
    send(4'd8, 5'd3, 5'd4, 5'd0, 5'd0, 32'h0000_0010, 1, 32'h1064_0010, 0);
    send(4'd9, 5'd5, 5'd1, 5'd0, 5'd0, 32'h0000_BEEF, 1, 32'h3C01_BEEF, 0);
    send(4'd11, 5'd0, 5'd0, 5'd0, 5'd0, 32'hFC00_0040, 1, 32'h0800_0040, 0);
    send(4'd13, 5'd4, 5'd7, 5'd3, 5'd0, 32'd0, 1, 32'h0080_1821, 0);
    send(4'd14, 5'd4, 5'd7, 5'd3, 5'd2, 32'hFFFF_FFFF, 1, 32'h0000_0000, 0);
    send(4'd12, 5'd0, 5'd8, 5'd0, 5'd0, 32'h0000_00FF, 1, 32'h3408_00FF, 0);
    send(4'd12, 5'd0, 5'd8, 5'd0, 5'd0, 32'hABCD_0000, 1, 32'h3C08_ABCD, 0);

    send(4'd12, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678, 2, 32'h3C08_1234, 32'h3508_5678);
    @(negedge clk);
    chk("li_ready_low", {31'd0, in_ready}, 0);
    to_drive();
    drain();

    to_drive();
    out_ready = 1'b0;
    send(4'd10, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0010_0000, 1, 32'h0C10_0000, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("jal_hold_valid", {31'd0, out_valid}, 1);
      chk("jal_hold_instr", out_instr, 32'h0C10_0000);
      chk("jal_hold_ready", {31'd0, in_ready}, 0);
    end
    to_drive();
    out_ready = 1'b1;
    drain();

    to_drive();
    send(4'd15, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 0, 0, 0);
    @(negedge clk);
    chk("illegal_err", {31'd0, err}, 1);
    chk("illegal_novalid", {31'd0, out_valid}, 0);
    @(negedge clk);
    chk("illegal_err_pulse", {31'd0, err}, 0);
    to_drive();
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 1, 32'h0022_1821, 0);
    send(4'd15, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 0);
    @(negedge clk);
    chk("hold_illegal_err", {31'd0, err}, 1);
    chk("hold_illegal_drain", {31'd0, out_valid}, 0);
    drain();
    chk("count_total", {16'd0, word_count}, pushed);

    to_drive();
    out_ready = 1'b0;
    send(4'd12, 5'd0, 5'd8, 5'd0, 5'd0, 32'h1234_5678, 2, 32'h3C08_1234, 32'h3508_5678);
    @(negedge clk);
    chk("mid_li_instr", out_instr, 32'h3C08_1234);
    chk("mid_li_last", {31'd0, out_last}, 0);
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 0);
    chk("async_rst_instr", out_instr, 32'h0);
    chk("async_rst_count", {16'd0, word_count}, 0);
    sb.delete();
    pushed = 0;
    to_drive();
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_ori_after_rst", {31'd0, out_valid}, 0);
      chk("ready_post_rst", {31'd0, in_ready}, 1);
    end
    to_drive();
    send(4'd0, 5'd1, 5'd2, 5'd3, 5'd0, 32'd0, 1, 32'h0022_1821, 0);
    send(4'd7, 5'd29, 5'd31, 5'd0, 5'd0, 32'h0000_FFFC, 1, 32'hAFBF_FFFC, 0);
    drain();
    chk("count_after_rst", {16'd0, word_count}, pushed);

    to_drive();
    b_op = 4'd14;
    b_valid = 1'b1;
    to_drive();
    b_valid = 1'b0;
    @(negedge clk);
    chk("np_nop_err", {31'd0, b_err}, 1);
    chk("np_nop_novalid", {31'd0, b_out_valid}, 0);
    to_drive();
    in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd3;
    b_op = 4'd0;
    b_valid = 1'b1;
    to_drive();
    b_valid = 1'b0;
    @(negedge clk);
    chk("np_addu_word", b_out_instr, 32'h0022_1821);
    to_drive();
    b_valid = 1'b1;
    repeat (2) to_drive();
    b_valid = 1'b0;
    repeat (3) to_drive();
    @(negedge clk);
    chk("np_count3", {30'd0, b_count}, 3);
    to_drive();
    b_valid = 1'b1;
    repeat (2) to_drive();
    b_valid = 1'b0;
    repeat (3) to_drive();
    @(negedge clk);
    chk("np_count_wrap", {30'd0, b_count}, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
